// File: rtl/dct_pkg.sv
// Shared constants, types and helpers for the 8-point row DCT pipeline.
package dct_pkg;

  localparam int DCT_N = 8;

  // Output lane k takes stage-5 term LANE_PERM[k].
  localparam int LANE_PERM [DCT_N] = '{0, 7, 3, 6, 1, 5, 2, 4};

  typedef enum logic {
    ROUND_FLOOR   = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_e;

  function automatic int dct_w(input int in_w);
    return in_w + 7;
  endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Drops FRAC_W guard bits (floor or round-half-up) and clamps to a signed OUT_W result.
module dct_round_sat
  import dct_pkg::*;
#(
  parameter int W      = 18,
  parameter int FRAC_W = 4,
  parameter int OUT_W  = 14,
  parameter int ROUND  = 1
) (
  input  logic signed [W-1:0]     i_v,
  output logic signed [OUT_W-1:0] o_q,
  output logic                    o_sat
);

  localparam logic [FRAC_W-1:0] HalfF = FRAC_W'(1) << (FRAC_W - 1);

  logic signed [W-1:0] w_sh;
  logic signed [W:0]   w_q;
  logic                w_inc;
  logic                w_pos;
  logic                w_neg;

  always_comb begin
    w_sh  = i_v >>> FRAC_W;
    w_inc = (ROUND == int'(ROUND_HALF_UP)) && (i_v[FRAC_W-1:0] >= HalfF);
    // One extra bit so the round-up increment cannot wrap.
    w_q   = {w_sh[W-1], w_sh} + {{W{1'b0}}, w_inc};
    w_pos = !w_q[W] && (|w_q[W-1:OUT_W-1]);
    w_neg = w_q[W] && !(&w_q[W-1:OUT_W-1]);
    o_sat = w_pos || w_neg;
    if (w_pos) begin
      o_q = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_neg) begin
      o_q = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o_q = w_q[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dct8_row_pipe.sv
// Five-stage 8-point forward DCT on one row per cycle, with a global stall enable,
// tag pass-through and per-lane saturating output.
module dct8_row_pipe
  import dct_pkg::*;
#(
  parameter int IN_W   = 11,
  parameter int OUT_W  = 14,
  parameter int FRAC_W = 4,
  parameter int ROUND  = 1,
  parameter int TAG_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DCT_N*IN_W-1:0]    i_data,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DCT_N*OUT_W-1:0]   o_data,
  output logic [TAG_W-1:0]         o_tag,
  output logic [DCT_N-1:0]         o_sat
);

  localparam int W = dct_w(IN_W);

  typedef logic signed [W-1:0] smp_t;

  // Constant arithmetic wraps at W bits; divisions truncate toward zero.
  function automatic smp_t mul_f(smp_t v);
    return v <<< FRAC_W;
  endfunction

  function automatic smp_t mul3(smp_t v);
    return (v <<< 1) + v;
  endfunction

  function automatic smp_t mul5(smp_t v);
    return (v <<< 2) + v;
  endfunction

  function automatic smp_t mul6(smp_t v);
    return (v <<< 2) + (v <<< 1);
  endfunction

  function automatic smp_t mul7(smp_t v);
    return (v <<< 3) - v;
  endfunction

  function automatic smp_t div8(smp_t v);
    smp_t t;
    t = v + (v[W-1] ? smp_t'(7) : smp_t'(0));
    return t >>> 3;
  endfunction

  function automatic smp_t div2(smp_t v);
    smp_t t;
    t = v + (v[W-1] ? smp_t'(1) : smp_t'(0));
    return t >>> 1;
  endfunction

  smp_t w_x [DCT_N];
  smp_t w_a [DCT_N];
  smp_t w_b [DCT_N];
  smp_t w_c [DCT_N];
  smp_t w_d [DCT_N];
  smp_t w_e [DCT_N];
  smp_t r_a [DCT_N];
  smp_t r_b [DCT_N];
  smp_t r_c [DCT_N];
  smp_t r_d [DCT_N];
  smp_t r_e [DCT_N];

  logic [4:0]       r_vld;
  logic [TAG_W-1:0] r_tag [5];
  logic             w_en;

  assign o_valid = r_vld[4];
  assign o_tag   = r_tag[4];
  assign w_en    = !(o_valid && !i_ready);
  assign o_ready = w_en;

  always_comb begin
    for (int k = 0; k < DCT_N; k++) begin
      w_x[k] = smp_t'(signed'(i_data[k*IN_W +: IN_W]));
    end

    w_a[0] = w_x[0] + w_x[7];
    w_a[1] = w_x[1] + w_x[6];
    w_a[2] = w_x[2] + w_x[5];
    w_a[3] = w_x[3] + w_x[4];
    w_a[4] = w_x[3] - w_x[4];
    w_a[5] = w_x[2] - w_x[5];
    w_a[6] = w_x[1] - w_x[6];
    w_a[7] = w_x[0] - w_x[7];

    w_b[0] = mul_f(r_a[3] + r_a[1]);
    w_b[1] = mul_f(r_a[2] + r_a[1]);
    w_b[2] = mul_f(r_a[1] - r_a[2]);
    w_b[3] = mul_f(r_a[0] - r_a[3]);
    w_b[4] = mul_f(r_a[4]);
    w_b[5] = mul_f(r_a[5]);
    w_b[6] = mul6(r_a[5]) + mul_f(r_a[6]);
    w_b[7] = mul_f(r_a[7]);

    w_c[0] = r_b[0] + r_b[1];
    w_c[1] = r_b[1];
    w_c[2] = r_b[2] - div8(mul3(r_b[3]));
    w_c[3] = r_b[3];
    w_c[4] = r_b[4];
    w_c[5] = div8(mul5(r_b[6])) - r_b[5];
    w_c[6] = r_b[7] - r_b[6];
    w_c[7] = r_b[6] + r_b[7];

    w_d[0] = r_c[0];
    w_d[1] = div2(r_c[0]) - r_c[1];
    w_d[2] = r_c[2];
    w_d[3] = r_c[3] + div8(mul3(r_c[2]));
    w_d[4] = r_c[4] + r_c[5] - div8(r_c[7]);
    w_d[5] = r_c[4] - r_c[5] + div8(mul7(r_c[6]));
    w_d[6] = r_c[6];
    w_d[7] = r_c[7];

    w_e    = r_d;
    w_e[6] = r_d[6] - div2(r_d[5]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DCT_N; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_c[k] <= '0;
        r_d[k] <= '0;
        r_e[k] <= '0;
      end
      for (int s = 0; s < 5; s++) begin
        r_tag[s] <= '0;
      end
      r_vld <= '0;
    end else if (w_en) begin
      r_a      <= w_a;
      r_b      <= w_b;
      r_c      <= w_c;
      r_d      <= w_d;
      r_e      <= w_e;
      r_vld    <= {r_vld[3:0], i_valid};
      r_tag[0] <= i_tag;
      for (int s = 1; s < 5; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  for (genvar k = 0; k < DCT_N; k++) begin : g_lane
    dct_round_sat #(
      .W      (W),
      .FRAC_W (FRAC_W),
      .OUT_W  (OUT_W),
      .ROUND  (ROUND)
    ) u_rs (
      .i_v   (r_e[LANE_PERM[k]]),
      .o_q   (o_data[k*OUT_W +: OUT_W]),
      .o_sat (o_sat[k])
    );
  end

endmodule

// File: tb/tb_dct8_row_pipe.sv
// Directed bench for dct8_row_pipe: three parameterisations share stimulus, a scoreboard
// queue holds model results and is checked when each output row is consumed.
module tb_dct8_row_pipe;

  localparam int FRAC = 4;

  typedef int row_t [8];
  typedef struct {
    logic [111:0] dr;
    logic [7:0]   sr;
    logic [111:0] df;
    logic [7:0]   sf;
    logic [95:0]  dw;
    logic [7:0]   sw;
    logic [3:0]   tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [87:0]  i_data = '0;
  logic [3:0]   i_tag = '0;

  logic         o_valid, o_ready, f_valid, f_ready, s_valid, s_ready;
  logic [111:0] o_data, f_data;
  logic [95:0]  s_data;
  logic [3:0]   o_tag, f_tag, s_tag;
  logic [7:0]   o_sat, f_sat, s_sat;

  exp_t         sb[$];
  exp_t         cur_exp;
  int           n_cmp = 0;
  int           n_err = 0;
  bit           prev_stall = 1'b0;
  int           stall_seen = 0;
  logic [111:0] snap_d;
  logic [3:0]   snap_t;
  logic [7:0]   snap_s;

  always #5 clk = ~clk;

  dct8_row_pipe #(.IN_W(11), .OUT_W(14), .FRAC_W(4), .ROUND(1), .TAG_W(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag),
    .o_sat(o_sat)
  );

  dct8_row_pipe #(.IN_W(11), .OUT_W(14), .FRAC_W(4), .ROUND(0), .TAG_W(4)) u_flr (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(f_ready), .i_data(i_data),
    .i_tag(i_tag), .o_valid(f_valid), .i_ready(i_ready), .o_data(f_data), .o_tag(f_tag),
    .o_sat(f_sat)
  );

  dct8_row_pipe #(.IN_W(11), .OUT_W(12), .FRAC_W(4), .ROUND(1), .TAG_W(4)) u_w12 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(s_ready), .i_data(i_data),
    .i_tag(i_tag), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data), .o_tag(s_tag),
    .o_sat(s_sat)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference transform straight from the stage equations, using int arithmetic.
  function automatic row_t dct_ref(row_t x);
    int a[8], b[8], c[8], d[8], e[8];
    row_t r;
    a[0] = x[0] + x[7]; a[1] = x[1] + x[6]; a[2] = x[2] + x[5]; a[3] = x[3] + x[4];
    a[4] = x[3] - x[4]; a[5] = x[2] - x[5]; a[6] = x[1] - x[6]; a[7] = x[0] - x[7];
    b[0] = (a[3] + a[1]) * 16; b[1] = (a[2] + a[1]) * 16; b[2] = (a[1] - a[2]) * 16;
    b[3] = (a[0] - a[3]) * 16; b[4] = a[4] * 16; b[5] = a[5] * 16;
    b[6] = 6 * a[5] + a[6] * 16; b[7] = a[7] * 16;
    c[0] = b[0] + b[1]; c[1] = b[1]; c[2] = b[2] - (3 * b[3]) / 8; c[3] = b[3];
    c[4] = b[4]; c[5] = (5 * b[6]) / 8 - b[5]; c[6] = b[7] - b[6]; c[7] = b[6] + b[7];
    d[0] = c[0]; d[1] = c[0] / 2 - c[1]; d[2] = c[2]; d[3] = c[3] + (3 * c[2]) / 8;
    d[4] = c[4] + c[5] - c[7] / 8; d[5] = c[4] - c[5] + (7 * c[6]) / 8;
    d[6] = c[6]; d[7] = c[7];
    e = d;
    e[6] = d[6] - d[5] / 2;
    r[0] = e[0]; r[1] = e[7]; r[2] = e[3]; r[3] = e[6];
    r[4] = e[1]; r[5] = e[5]; r[6] = e[2]; r[7] = e[4];
    return r;
  endfunction

  function automatic int rs_q(input int v, input int rnd, input int ow, output bit s);
    int q, hi, lo;
    q = v >>> FRAC;
    if (rnd != 0 && (v & 15) >= 8) q = q + 1;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    s = 1'b0;
    if (q > hi) begin q = hi; s = 1'b1; end
    if (q < lo) begin q = lo; s = 1'b1; end
    return q;
  endfunction

  function automatic logic [127:0] pack(row_t v, int ow);
    logic [127:0] r;
    int           t;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      t = v[k];
      for (int b = 0; b < ow; b++) r[k*ow+b] = t[b];
    end
    return r;
  endfunction

  function automatic exp_t make_exp(row_t x, logic [3:0] tag);
    exp_t         e;
    row_t         big, qr, qf, qw;
    bit           s;
    logic [127:0] p;
    big = dct_ref(x);
    e.sr = '0; e.sf = '0; e.sw = '0;
    for (int k = 0; k < 8; k++) begin
      qr[k] = rs_q(big[k], 1, 14, s); e.sr[k] = s;
      qf[k] = rs_q(big[k], 0, 14, s); e.sf[k] = s;
      qw[k] = rs_q(big[k], 1, 12, s); e.sw[k] = s;
    end
    p = pack(qr, 14); e.dr = p[111:0];
    p = pack(qf, 14); e.df = p[111:0];
    p = pack(qw, 12); e.dw = p[95:0];
    e.tag = tag;
    return e;
  endfunction

  task automatic drive(input row_t x, input logic [3:0] tag);
    int t;
    for (int k = 0; k < 8; k++) begin
      t = x[k];
      i_data[k*11 +: 11] = t[10:0];
    end
    i_tag   = tag;
    i_valid = 1'b1;
    cur_exp = make_exp(x, tag);
  endtask

  // One clock: check/consume at the falling edge, then advance past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (prev_stall) begin
      chk("frozen_data", 128'(o_data), 128'(snap_d));
      chk("frozen_tag", 128'(o_tag), 128'(snap_t));
      chk("frozen_sat", 128'(o_sat), 128'(snap_s));
    end
    prev_stall = o_valid && !i_ready;
    if (prev_stall) begin
      stall_seen++;
      chk("stall_ready", 128'({o_ready, f_ready, s_ready}), 128'(0));
      snap_d = o_data; snap_t = o_tag; snap_s = o_sat;
    end
    if (o_valid && i_ready) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid_all", 128'({f_valid, s_valid}), 128'(2'b11));
        chk("data_r", 128'(o_data), 128'(e.dr));
        chk("sat_r", 128'(o_sat), 128'(e.sr));
        chk("data_f", 128'(f_data), 128'(e.df));
        chk("sat_f", 128'(f_sat), 128'(e.sf));
        chk("data_w12", 128'(s_data), 128'(e.dw));
        chk("sat_w12", 128'(s_sat), 128'(e.sw));
        chk("tags", 128'({o_tag, f_tag, s_tag}), 128'({e.tag, e.tag, e.tag}));
      end
    end
    if (i_valid && o_ready) begin
      sb.push_back(cur_exp);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting tick; counts edges until o_valid rises.
  task automatic wait_valid(input string tag);
    int n;
    bit acc;
    n = 1;
    while (!o_valid && n < 20) begin
      tick(acc);
      n++;
    end
    chk(tag, 128'(n), 128'(5));
  endtask

  row_t x, ex;
  row_t rows [8];
  bit   acc;
  int   idx, cyc;

  initial begin
    // Reset then idle.
    rst = 1'b1;
    tick(acc); tick(acc);
    rst = 1'b0;
    tick(acc);
    chk("rst_valid", 128'({o_valid, f_valid, s_valid}), 128'(0));
    chk("rst_ready", 128'({o_ready, f_ready, s_ready}), 128'(3'b111));
    chk("rst_data", 128'(o_data), 128'(0));
    chk("rst_sat", 128'(o_sat), 128'(0));
    chk("rst_tag", 128'(o_tag), 128'(0));

    // DC row.
    x = '{10, 10, 10, 10, 10, 10, 10, 10};
    drive(x, 4'd3);
    tick(acc);
    i_valid = 1'b0;
    wait_valid("dc_latency");
    ex = '{80, 0, 0, 0, 0, 0, 0, 0};
    chk("dc_const", 128'(o_data), pack(ex, 14));
    chk("dc_tag", 128'(o_tag), 128'(3));
    chk("dc_sat", 128'(o_sat), 128'(0));
    tick(acc);

    // Impulse, both rounding modes.
    x = '{1, 0, 0, 0, 0, 0, 0, 0};
    drive(x, 4'd5);
    tick(acc);
    i_valid = 1'b0;
    wait_valid("imp_latency");
    ex = '{0, 1, 1, 1, 0, 1, 0, 0};
    chk("imp_round", 128'(o_data), pack(ex, 14));
    ex = '{0, 1, 0, 0, 0, 0, -1, -1};
    chk("imp_floor", 128'(f_data), pack(ex, 14));
    tick(acc);

    // Saturation on the 12-bit instance.
    x = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    drive(x, 4'd9);
    tick(acc);
    i_valid = 1'b0;
    wait_valid("sat_latency");
    ex = '{2047, 0, 0, 0, 0, 0, 0, 0};
    chk("sat_w12_const", 128'(s_data), pack(ex, 12));
    chk("sat_w12_flag", 128'(s_sat), 128'(8'b0000_0001));
    tick(acc);

    // Stream 8 tagged rows with a downstream stall from cycle 3 for 6 cycles.
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) rows[r][k] = int'($urandom_range(0, 400)) - 200;
    idx = 0;
    cyc = 0;
    while (cyc < 60 && (idx < 8 || sb.size() != 0)) begin
      i_ready = !(cyc >= 3 && cyc < 9);
      if (idx < 8) drive(rows[idx], 4'(idx + 1));
      else i_valid = 1'b0;
      tick(acc);
      if (acc) idx++;
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("stream_sent", 128'(idx), 128'(8));
    chk("stream_drained", 128'(sb.size()), 128'(0));
    chk("stall_observed", 128'(stall_seen >= 4), 128'(1));

    // Reset with four rows in flight.
    for (int r = 0; r < 4; r++) begin
      drive(rows[r], 4'(r + 10));
      tick(acc);
    end
    i_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    sb.delete();
    chk("midrst_valid", 128'(o_valid), 128'(0));
    chk("midrst_data", 128'(o_data), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      chk("no_stale", 128'(o_valid), 128'(0));
    end
    drive(rows[7], 4'd14);
    tick(acc);
    i_valid = 1'b0;
    wait_valid("fresh_latency");
    tick(acc);
    chk("final_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct8_row_pipe.md
# dct8_row_pipe

- Parametrised, back-pressurable 8-point 1D forward DCT for the preprocessing datapath; one row per cycle.
- Sits between the level-shift/row-buffer stage and the transpose buffer that feeds the column pass.
- Input width, output width, fractional guard bits, rounding mode and a sideband tag are parameters.
- Adds ready/valid stall, per-lane output saturation with flags, and tag pass-through.

## Interface
- IN_W, 11, signed input sample width
- OUT_W, 14, signed output coefficient width
- FRAC_W, 4, fractional guard bits; F = 2^FRAC_W
- ROUND, 1, 0 = floor (arithmetic shift), 1 = round-half-up
- TAG_W, 4, sideband tag width (minimum 1)
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high (clock i_clk)
- i_valid  in  1  input row valid
- o_ready  out  1  block can accept a row this cycle
- i_data  in  8*IN_W  packed samples; x[k] = i_data[k*IN_W +: IN_W]
- i_tag  in  TAG_W  sideband, travels with the row
- o_valid  out  1  output row valid
- i_ready  in  1  downstream accepts the output row
- o_data  out  8*OUT_W  packed coefficients; lane k = X[k]
- o_tag  out  TAG_W  tag of the output row
- o_sat  out  8  per-lane flag: lane k was clamped

## Operation
- Internal width W = IN_W+7, FRAC_W+3 margin included. Every stage result is a signed W-bit value.
- All `/` operations are signed division truncating toward zero: -18/8 = -2.
- Constant multiplies are exact at W bits.
- S1: a0=x0+x7, a1=x1+x6, a2=x2+x5, a3=x3+x4, a4=x3-x4, a5=x2-x5, a6=x1-x6, a7=x0-x7.
- S2: b0=(a3+a1)F, b1=(a2+a1)F, b2=(a1-a2)F, b3=(a0-a3)F, b4=a4F, b5=a5F, b6=6*a5+a6F, b7=a7F.
- S3: c0=b0+b1, c1=b1, c2=b2-(3*b3)/8, c3=b3, c4=b4, c5=(5*b6)/8-b5, c6=b7-b6, c7=b6+b7.
- S4:
  - d0=c0, d1=c0/2-c1, d2=c2, d3=c3+(3*c2)/8
  - d4=c4+c5-c7/8, d5=c4-c5+(7*c6)/8, d6=c6, d7=c7
- S5: e = d, except e6=d6-d5/2.
- Output lane mapping: X0=e0, X1=e7, X2=e3, X3=e6, X4=e1, X5=e5, X6=e2, X7=e4.
- Round/saturate, per lane, combinational from the S5 register:
  - q = v >>> FRAC_W (floor).
  - If ROUND=1 and v[FRAC_W-1:0] >= F/2, then q = q+1.
  - Clamp q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - o_sat[k] = 1 when clamping occurred.
- Tag and valid advance alongside the data in every stage.

## Timing
- Five register stages S1..S5. Latency is 5 cycles from an accepted input to o_valid when unstalled. Throughput is 1 row/cycle.
- Global advance enable: en = !(o_valid && !i_ready); o_ready = en.
- A row is accepted when i_valid && o_ready. All stage registers, including valids and tags, load only when en=1.
- Stall: o_valid && !i_ready freezes all five stages.
  - o_data, o_tag and o_sat hold stable.
  - Up to 5 rows are held; none is lost or duplicated.
- i_valid=0 while en=1 inserts a bubble; the stage valid shifts in 0.
- Simultaneous accept and output-consume in the same cycle is legal and loses no row.
- Reset: every stage register clears to 0 and every valid clears to 0. This gives o_valid=0, o_data=0, o_tag=0, o_sat=0, o_ready=1 the cycle after i_rst is sampled.
- Reset overrides any stall and discards in-flight rows.

## Structure
- Package dct_pkg holds:
  - constant DCT_N=8
  - the output lane permutation array
  - the rounding-mode enum ROUND_FLOOR=0 / ROUND_HALF_UP=1
  - function dct_w(IN_W) = IN_W+7
- Sub-module dct_round_sat: params W, FRAC_W, OUT_W, ROUND; input v; outputs q and sat. It is instantiated 8 times.
- Stage logic and valid/tag shift chain stay in dct8_row_pipe.

## Test plan
- Reset then idle -> o_valid=0, o_ready=1, o_data all 0, o_sat=0.
- DC row, all x=10, i_tag=3, i_ready=1 -> 5 cycles later o_valid=1, X0=80, X1..X7=0, o_tag=3, o_sat=0.
- Impulse x0=1, others 0:
  - ROUND=1 -> X = {0,1,1,1,0,1,0,0}.
  - ROUND=0 -> X = {0,1,0,0,0,0,-1,-1}.
- OUT_W=12, all x=1023 -> X0=2047, o_sat=8'b0000_0001, other lanes 0 unflagged.
- Stream 8 distinct tagged rows with i_ready=0 from cycle 3 for 6 cycles:
  - o_ready drops as soon as o_valid=1 with i_ready=0.
  - Outputs stay frozen during the stall.
  - After release all 8 rows emerge in order, bit-exact against the model.
- Assert i_rst for 1 cycle with 4 rows in flight -> next cycle o_valid=0, o_data=0. No stale row emerges later; a fresh row afterwards has 5-cycle latency.
